// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the SDLX MEM-stage load/store unit.
package load_store_unit_pkg;

  // Sequencer states: load, word store and read-modify-write store paths.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    RMW_RD  = 3'd4,
    RMW_MRG = 3'd5,
    RMW_WR  = 3'd6
  } state_t;

  // Access size codes carried on req_size.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // True when the size code is illegal or the byte address is not
  // naturally aligned for that size.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response handshake of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // Pipeline side: issues requests, consumes responses.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Unit side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Little-endian lane handling: load extraction with sign/zero extension
// and sub-word merge for read-modify-write stores. Purely combinational.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  // Alignment is guaranteed before we get here, so a byte-granular shift
  // also lands halfwords on the right lane.
  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;

  assign shamt   = {addr_lo, 3'b000};
  assign shifted = word >> shamt;

  // Extract the addressed lane and extend it to 32 bits.
  always_comb begin
    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default: load_data = word;
    endcase
  end

  // Replace only the addressed lane of the old word with store data.
  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: lane_mask = 32'h0000_00FF << shamt;
      SZ_HALF: lane_mask = 32'h0000_FFFF << shamt;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
    merged = (word & ~lane_mask) | ((wdata << shamt) & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: accepts pipeline requests, sequences the
// word-addressed DataMemory port and returns a one-cycle response pulse.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  load_store_unit_if.slave lsu,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  output logic        MemRead,
  output logic        MemWrite
);

  localparam logic [31:0] MEM_LIMIT = MEM_WORDS;

  state_t      state_reg;
  logic [1:0]  addr_lo_reg;
  logic [1:0]  size_reg;
  logic        signed_reg;
  logic [31:0] wdata_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_writedata_reg;
  logic        resp_valid_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_err_reg;

  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Faults are decided entirely from the incoming request.
  assign req_err = is_misaligned(lsu.req_size, lsu.req_addr[1:0]) ||
                   ({2'b00, lsu.req_addr[31:2]} >= MEM_LIMIT);

  lsu_lane_align u_align (
    .word      (mem_readdata),
    .addr_lo   (addr_lo_reg),
    .size      (size_reg),
    .is_signed (signed_reg),
    .wdata     (wdata_reg),
    .load_data (load_data),
    .merged    (merged)
  );

  // Strobes come straight from the state so reset kills them at once.
  assign MemRead  = (state_reg == RD) || (state_reg == RMW_RD);
  assign MemWrite = (state_reg == WR) || (state_reg == RMW_WR);

  assign lsu.req_ready  = (state_reg == IDLE);
  assign lsu.resp_valid = resp_valid_reg;
  assign lsu.resp_rdata = resp_rdata_reg;
  assign lsu.resp_err   = resp_err_reg;
  assign mem_addr       = mem_addr_reg;
  assign mem_writedata  = mem_writedata_reg;

  // Sequencer: request latching, memory port and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg         <= IDLE;
      addr_lo_reg       <= 2'b00;
      size_reg          <= 2'b00;
      signed_reg        <= 1'b0;
      wdata_reg         <= 32'h0;
      mem_addr_reg      <= 32'h0;
      mem_writedata_reg <= 32'h0;
      resp_valid_reg    <= 1'b0;
      resp_rdata_reg    <= 32'h0;
      resp_err_reg      <= 1'b0;
    end else begin
      // Response is a single-cycle pulse; data reads as zero unless a
      // load completes this cycle.
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'h0;
      case (state_reg)
        IDLE: begin
          if (lsu.req_valid) begin
            if (req_err) begin
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
            end else begin
              addr_lo_reg  <= lsu.req_addr[1:0];
              size_reg     <= lsu.req_size;
              signed_reg   <= lsu.req_signed;
              wdata_reg    <= lsu.req_wdata;
              mem_addr_reg <= {2'b00, lsu.req_addr[31:2]};
              if (!lsu.req_write) begin
                state_reg <= RD;
              end else if (lsu.req_size == SZ_WORD) begin
                mem_writedata_reg <= lsu.req_wdata;
                state_reg         <= WR;
              end else begin
                state_reg <= RMW_RD;
              end
            end
          end
        end
        RD: state_reg <= RD_DATA;
        RD_DATA: begin
          resp_valid_reg <= 1'b1;
          resp_rdata_reg <= load_data;
          state_reg      <= IDLE;
        end
        WR: begin
          resp_valid_reg <= 1'b1;
          state_reg      <= IDLE;
        end
        RMW_RD: state_reg <= RMW_MRG;
        RMW_MRG: begin
          mem_writedata_reg <= merged;
          state_reg         <= RMW_WR;
        end
        RMW_WR: begin
          resp_valid_reg <= 1'b1;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit paired with a registered-read
// DataMemory model preloaded with mem[i] = i.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        MemRead;
  logic        MemWrite;
  logic        preload = 1'b1;
  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  load_store_unit_if bus();

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk           (clk),
    .reset         (reset),
    .lsu           (bus),
    .mem_addr      (mem_addr),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite)
  );

  always #5 clk = ~clk;

  // DataMemory model: one-cycle registered read, synchronous write.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= i;
      mem_readdata <= 32'h0;
    end else begin
      if (MemWrite) mem[mem_addr[7:0]] <= mem_writedata;
      if (MemRead) mem_readdata <= mem[mem_addr[7:0]];
    end
  end

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_maddr;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic wr, logic [1:0] size,
                              logic sgn, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] exp_rdata,
                              logic exp_err, int exp_lat, int exp_rd,
                              int exp_wr, logic [31:0] exp_maddr,
                              logic [31:0] exp_wd);
    vec_t v;
    v.name = name; v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    v.exp_lat = exp_lat; v.exp_rd = exp_rd; v.exp_wr = exp_wr;
    v.exp_maddr = exp_maddr; v.exp_wd = exp_wd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  // Issue one request and observe strobes/response until the pulse.
  task automatic run_vec(input vec_t v);
    int rd, wr, lat;
    rd = 0; wr = 0; lat = -1;
    @(negedge clk);
    drive(v.wr, v.size, v.sgn, v.addr, v.wdata);
    chk({v.name, " ready"}, {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (MemRead) begin
        rd++;
        chk({v.name, " rd_addr"}, mem_addr, v.exp_maddr);
      end
      if (MemWrite) begin
        wr++;
        chk({v.name, " wr_addr"}, mem_addr, v.exp_maddr);
        chk({v.name, " wr_data"}, mem_writedata, v.exp_wd);
      end
      if (MemRead && MemWrite) chk({v.name, " both_strobes"}, 32'd1, 32'd0);
      if (bus.resp_valid) begin
        lat = k;
        break;
      end
    end
    chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({v.name, " rdata"}, bus.resp_rdata, v.exp_rdata);
    chk({v.name, " err"}, {31'b0, bus.resp_err}, {31'b0, v.exp_err});
    chk({v.name, " rd_cycles"}, 32'(rd), 32'(v.exp_rd));
    chk({v.name, " wr_cycles"}, 32'(wr), 32'(v.exp_wr));
    @(negedge clk);
    chk({v.name, " pulse"}, {31'b0, bus.resp_valid}, 32'd0);
    $display("txn %-14s addr=%h lat=%0d rdata=%h err=%b", v.name, v.addr,
             lat, v.exp_rdata, v.exp_err);
  endtask

  initial begin
    int acc[$];
    logic [31:0] res[$];
    int busy_seen;
    int bad_activity;
    logic accepting;

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst MemRead", {31'b0, MemRead}, 32'd0);
    chk("rst MemWrite", {31'b0, MemWrite}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_writedata, 32'h0);
    chk("rst resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst resp_err", {31'b0, bus.resp_err}, 32'd0);
    @(negedge clk);
    preload = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst ready", {31'b0, bus.req_ready}, 32'd1);
    $display("txn reset released");

    //          name           wr  sz  sg addr          wdata         exp_rdata     err lat rd wr maddr  exp_wd
    vecs.push_back(mk("ld_w_14",    0, 2, 0, 32'h14,  32'h0,        32'h0000_0005, 0, 2, 1, 0, 32'd5,   32'h0));
    vecs.push_back(mk("st_w_20",    1, 2, 0, 32'h20,  32'hDEADBEEF, 32'h0,         0, 1, 0, 1, 32'd8,   32'hDEADBEEF));
    vecs.push_back(mk("ld_w_20",    0, 2, 0, 32'h20,  32'h0,        32'hDEADBEEF,  0, 2, 1, 0, 32'd8,   32'h0));
    vecs.push_back(mk("st_b_21",    1, 0, 0, 32'h21,  32'h000000AB, 32'h0,         0, 3, 1, 1, 32'd8,   32'hDEADABEF));
    vecs.push_back(mk("ld_bs_21",   0, 0, 1, 32'h21,  32'h0,        32'hFFFFFFAB,  0, 2, 1, 0, 32'd8,   32'h0));
    vecs.push_back(mk("ld_bu_21",   0, 0, 0, 32'h21,  32'h0,        32'h000000AB,  0, 2, 1, 0, 32'd8,   32'h0));
    vecs.push_back(mk("ld_hs_22",   0, 1, 1, 32'h22,  32'h0,        32'hFFFFDEAD,  0, 2, 1, 0, 32'd8,   32'h0));
    vecs.push_back(mk("ld_hu_20",   0, 1, 0, 32'h20,  32'h0,        32'h0000ABEF,  0, 2, 1, 0, 32'd8,   32'h0));
    vecs.push_back(mk("st_h_1e",    1, 1, 0, 32'h1E,  32'hFFFF1234, 32'h0,         0, 3, 1, 1, 32'd7,   32'h12340007));
    vecs.push_back(mk("ld_w_1c",    0, 2, 0, 32'h1C,  32'h0,        32'h12340007,  0, 2, 1, 0, 32'd7,   32'h0));
    vecs.push_back(mk("ld_bs_3fc",  0, 0, 1, 32'h3FC, 32'h0,        32'hFFFFFFFF,  0, 2, 1, 0, 32'd255, 32'h0));
    vecs.push_back(mk("err_h_23",   0, 1, 0, 32'h23,  32'h0,        32'h0,         1, 0, 0, 0, 32'd0,   32'h0));
    vecs.push_back(mk("err_w_02",   0, 2, 0, 32'h02,  32'h0,        32'h0,         1, 0, 0, 0, 32'd0,   32'h0));
    vecs.push_back(mk("err_sz3",    0, 3, 0, 32'h00,  32'h0,        32'h0,         1, 0, 0, 0, 32'd0,   32'h0));
    vecs.push_back(mk("err_w_400",  0, 2, 0, 32'h400, 32'h0,        32'h0,         1, 0, 0, 0, 32'd0,   32'h0));
    vecs.push_back(mk("err_stw400", 1, 2, 0, 32'h400, 32'h12345678, 32'h0,         1, 0, 0, 0, 32'd0,   32'h0));
    vecs.push_back(mk("err_sth_21", 1, 1, 0, 32'h21,  32'h5555,     32'h0,         1, 0, 0, 0, 32'd0,   32'h0));
    vecs.push_back(mk("ld_w_20b",   0, 2, 0, 32'h20,  32'h0,        32'hDEADABEF,  0, 2, 1, 0, 32'd8,   32'h0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset pulsed while the RMW is in its merge cycle.
    @(negedge clk);
    drive(1'b1, 2'd0, 1'b0, 32'h22, 32'h00000055);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_abort RD strobe", {31'b0, MemRead}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rmw_abort MemRead", {31'b0, MemRead}, 32'd0);
    chk("rmw_abort MemWrite", {31'b0, MemWrite}, 32'd0);
    bad_activity = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (MemWrite || MemRead || bus.resp_valid) bad_activity++;
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (MemWrite || bus.resp_valid) bad_activity++;
    end
    chk("rmw_abort activity", 32'(bad_activity), 32'd0);
    chk("rmw_abort ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rmw_abort mem8", mem[8], 32'hDEADABEF);
    $display("txn reset during RMW_MRG");
    run_vec(mk("ld_after_rst", 0, 2, 0, 32'h20, 32'h0, 32'hDEADABEF, 0, 2, 1, 0, 32'd8, 32'h0));

    // Reset while MemRead is high must drop the strobe asynchronously.
    @(negedge clk);
    drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rd_abort strobe_on", {31'b0, MemRead}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rd_abort MemRead", {31'b0, MemRead}, 32'd0);
    chk("rd_abort mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    chk("rd_abort resp", {31'b0, bus.resp_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rd_abort ready", {31'b0, bus.req_ready}, 32'd1);
    $display("txn reset during RD");

    // Back-to-back loads with req_valid held high.
    busy_seen = 0;
    @(negedge clk);
    drive(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 20; c++) begin
      if (bus.resp_valid) res.push_back(bus.resp_rdata);
      accepting = bus.req_valid && bus.req_ready;
      if (accepting) acc.push_back(c);
      else if (bus.req_valid) busy_seen++;
      @(posedge clk); #1;
      if (accepting) begin
        if (acc.size() < 3) bus.req_addr = 32'(acc.size() * 4);
        else bus.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b accepts", 32'(acc.size()), 32'd3);
    chk("b2b responses", 32'(res.size()), 32'd3);
    chk("b2b busy_ready_low", 32'(busy_seen), 32'd4);
    if (acc.size() == 3) begin
      chk("b2b gap1", 32'(acc[1] - acc[0]), 32'd3);
      chk("b2b gap2", 32'(acc[2] - acc[1]), 32'd3);
    end
    for (int i = 0; i < res.size() && i < 3; i++)
      chk($sformatf("b2b result%0d", i), res[i], 32'(i));
    $display("txn back-to-back loads accepts=%0d responses=%0d",
             acc.size(), res.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $finish;
  end

endmodule
